// File: rtl/logic_eval_fifo_if.sv
// Operand-side and result-side valid/ready bundle for logic_eval_fifo.
// The block itself takes the slave modport; producers and consumers take master.
interface logic_eval_fifo_if #(
    parameter int WIDTH = 8
);
    localparam int ONES_W = $clog2(WIDTH + 1);

    logic              in_valid;
    logic              in_ready;
    logic [1:0]        mode;
    logic [WIDTH-1:0]  port_a;
    logic [WIDTH-1:0]  port_b;
    logic [WIDTH-1:0]  port_c;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_q;
    logic [ONES_W-1:0] out_ones;

    modport master (
        output in_valid, mode, port_a, port_b, port_c, out_ready,
        input  in_ready, out_valid, out_q, out_ones
    );

    modport slave (
        input  in_valid, mode, port_a, port_b, port_c, out_ready,
        output in_ready, out_valid, out_q, out_ones
    );
endinterface

// File: rtl/logic_eval_fifo.sv
// Selectable bitwise function of A/B/C, queued with its popcount in an output FIFO,
// plus a saturating count of accepted non-zero results.
module logic_eval_fifo #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    logic_eval_fifo_if.slave              bus,
    input  logic                          cnt_clr,
    output logic [CNT_W-1:0]              match_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int ONES_W = $clog2(WIDTH + 1);
    localparam logic [PTR_W:0] LVL_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    logic [WIDTH-1:0]  q_mem    [FIFO_DEPTH];
    logic [ONES_W-1:0] ones_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [WIDTH-1:0]  result;
    logic [ONES_W-1:0] result_ones;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    always_comb begin
        result = '0;
        case (bus.mode)
            2'b00: result = bus.port_b & (bus.port_a | bus.port_c);
            2'b01: result = bus.port_a & bus.port_b;
            2'b10: result = bus.port_a | bus.port_b | bus.port_c;
            2'b11: result = bus.port_a ^ bus.port_b ^ bus.port_c;
            default: result = '0;
        endcase
    end

    always_comb begin
        result_ones = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            result_ones = result_ones + ONES_W'(result[i]);
        end
    end

    // Ready depends on the registered level only, so a full FIFO refuses a push
    // even while it is being popped in the same cycle.
    assign full         = (fifo_level == LVL_FULL);
    assign empty        = (fifo_level == '0);
    assign bus.in_ready = !full;
    assign push         = bus.in_valid && !full;
    assign bus.out_valid = !empty;
    assign pop          = !empty && bus.out_ready;

    assign bus.out_q    = empty ? '0 : q_mem[rd_ptr];
    assign bus.out_ones = empty ? '0 : ones_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr]    <= result;
            ones_mem[wr_ptr] <= result_ones;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + (PTR_W + 1)'(1);
                2'b01:   fifo_level <= fifo_level - (PTR_W + 1)'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= '0;
        end else if (push && (result != '0) && (match_cnt != '1)) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_logic_eval_fifo.sv
// Self-checking bench for logic_eval_fifo: vector table plus hand-written
// backpressure, counter and reset sequences, all results checked via a scoreboard.
module tb_logic_eval_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] match_cnt;
    logic [2:0]       fifo_level;

    logic_eval_fifo_if #(.WIDTH(WIDTH)) bus ();

    logic_eval_fifo #(
        .WIDTH(WIDTH),
        .FIFO_DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .cnt_clr(cnt_clr),
        .match_cnt(match_cnt),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] q;
        logic [3:0] ones;
    } exp_t;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] exp_q;
        int         exp_ones;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    int   exp_cnt  = 0;
    vec_t vecs[10];

    function automatic logic [7:0] model(logic [1:0] m, logic [7:0] a, logic [7:0] b, logic [7:0] c);
        case (m)
            2'b00:   return b & (a | c);
            2'b01:   return a & b;
            2'b10:   return a | b | c;
            default: return a ^ b ^ c;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [1:0] m, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] c);
        bus.in_valid = v;
        bus.mode     = m;
        bus.port_a   = a;
        bus.port_b   = b;
        bus.port_c   = c;
    endtask

    // Reference model: expected entries and counter tracked at the accepting edge.
    always @(posedge clk) begin
        if (rst_n) begin
            logic [7:0] r;
            logic       acc;
            acc = bus.in_valid && bus.in_ready;
            r   = model(bus.mode, bus.port_a, bus.port_b, bus.port_c);
            if (acc) sb.push_back({r, 4'($countones(r))});
            if (cnt_clr) exp_cnt = 0;
            else if (acc && r != 8'h00 && exp_cnt < 3) exp_cnt++;
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_q", int'(bus.out_q), int'(e.q));
                check("sb_ones", int'(bus.out_ones), int'(e.ones));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{2'b00, 8'hF0, 8'hCC, 8'h0F, 8'hCC, 4};
        vecs[1] = '{2'b01, 8'hF0, 8'hCC, 8'h0F, 8'hC0, 2};
        vecs[2] = '{2'b10, 8'hF0, 8'hCC, 8'h0F, 8'hFF, 8};
        vecs[3] = '{2'b11, 8'hF0, 8'hCC, 8'h0F, 8'h33, 4};
        vecs[4] = '{2'b00, 8'h00, 8'hFF, 8'h00, 8'h00, 0};
        vecs[5] = '{2'b10, 8'h55, 8'hAA, 8'h00, 8'hFF, 8};
        vecs[6] = '{2'b01, 8'h55, 8'hAA, 8'h00, 8'h00, 0};
        vecs[7] = '{2'b11, 8'h55, 8'hAA, 8'h00, 8'hFF, 8};
        vecs[8] = '{2'b00, 8'h81, 8'h81, 8'h7E, 8'h81, 2};
        vecs[9] = '{2'b11, 8'h01, 8'h03, 8'h07, 8'h05, 2};

        set_in(1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
        bus.out_ready = 1'b0;
        repeat (2) step();
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_cnt", int'(match_cnt), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_q", int'(bus.out_q), 0);
        check("rst_out_ones", int'(bus.out_ones), 0);
        rst_n = 1'b1;
        step();

        // Single-item latency and function table.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].c);
            step();
            set_in(1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
            check("vec_valid", int'(bus.out_valid), 1);
            check("vec_q", int'(bus.out_q), int'(vecs[i].exp_q));
            check("vec_ones", int'(bus.out_ones), vecs[i].exp_ones);
            check("vec_cnt", int'(match_cnt), exp_cnt);
            if (i == 0) check("first_cnt", int'(match_cnt), 1);
            step();
            check("vec_level", int'(fifo_level), 0);
        end

        // Fill under backpressure, then a pop-only cycle while full.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 2'b11, 8'(i * 17), 8'h5A, 8'(i));
            step();
        end
        check("full_level", int'(fifo_level), 4);
        check("full_in_ready", int'(bus.in_ready), 0);
        check("full_sb_size", sb.size(), 4);
        bus.out_ready = 1'b1;
        step();
        check("full_pop_no_push", int'(fifo_level), 3);
        for (int k = 0; k < 10; k++) begin
            set_in(1'b1, 2'b00 + 2'(k), 8'(k * 29 + 3), 8'hA5, 8'(k * 7));
            step();
            check("stream_level", int'(fifo_level), 3);
        end
        set_in(1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
        for (int k = 0; k < 20 && bus.out_valid; k++) step();
        check("drain_valid", int'(bus.out_valid), 0);
        check("drain_sb_empty", sb.size(), 0);
        check("drain_out_q", int'(bus.out_q), 0);

        // Zero result leaves the counter alone.
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("clr_cnt", int'(match_cnt), 0);
        set_in(1'b1, 2'b00, 8'h00, 8'hFF, 8'h00);
        step();
        set_in(1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
        check("zero_valid", int'(bus.out_valid), 1);
        check("zero_q", int'(bus.out_q), 0);
        check("zero_ones", int'(bus.out_ones), 0);
        check("zero_cnt", int'(match_cnt), 0);
        step();

        // Saturation at 3, then clear beating a coincident increment.
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 2'b10, 8'(i + 1), 8'h00, 8'h00);
            step();
            check("sat_cnt", int'(match_cnt), (i + 1 > 3) ? 3 : i + 1);
        end
        cnt_clr = 1'b1;
        set_in(1'b1, 2'b10, 8'h42, 8'h00, 8'h00);
        step();
        cnt_clr = 1'b0;
        set_in(1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
        check("clr_priority", int'(match_cnt), 0);
        for (int k = 0; k < 10 && bus.out_valid; k++) step();
        check("sat_drain", sb.size(), 0);

        // Asynchronous reset with entries queued.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 2'b10, 8'(8'h10 + i), 8'h01, 8'h00);
            step();
        end
        set_in(1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
        check("pre_rst_level", int'(fifo_level), 3);
        check("pre_rst_cnt", int'(match_cnt), 3);
        #3;
        rst_n = 1'b0;
        sb.delete();
        exp_cnt = 0;
        #1;
        check("async_out_valid", int'(bus.out_valid), 0);
        check("async_level", int'(fifo_level), 0);
        check("async_out_q", int'(bus.out_q), 0);
        check("async_cnt", int'(match_cnt), 0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", int'(bus.in_ready), 1);
        check("post_rst_cnt", int'(match_cnt), 0);
        check("post_rst_valid", int'(bus.out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/logic_eval_fifo.md
Name: logic_eval_fifo

Overview:
- Parametrised, registered successor to the team's fixed single-bit logic-function blocks.
- Evaluates one of four selectable bitwise functions over WIDTH-bit operands A, B and C.
- Stores each result with its population count in an output FIFO, using valid/ready handshakes on both sides.
- Keeps a saturating count of non-zero results. Sits between operand producers and downstream consumers in the dependence test datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- FIFO_DEPTH, 4, number of output FIFO entries; power of 2, >=2.
- CNT_W, 16, width of the match counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept an operand set.
- mode  input  2  function select, sampled with the operands.
- port_a  input  WIDTH  operand A.
- port_b  input  WIDTH  operand B.
- port_c  input  WIDTH  operand C.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts the head.
- out_q  output  WIDTH  result at the FIFO head.
- out_ones  output  $clog2(WIDTH+1)  number of 1 bits in out_q.
- cnt_clr  input  1  synchronous clear of match_cnt.
- match_cnt  output  CNT_W  count of accepted results that were non-zero.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current number of FIFO entries.

Behaviour:
- Clock and reset: single clock domain. rst_n low asynchronously empties the FIFO (pointers = 0, level = 0) and clears match_cnt to 0.
- Output values during and after reset: out_valid=0, fifo_level=0, match_cnt=0, in_ready=1. out_q and out_ones are 0 while the FIFO is empty.
- Mode functions, all bitwise:
  - 00: B & (A | C)
  - 01: A & B
  - 10: A | B | C
  - 11: A ^ B ^ C
- Accept: an input transfer occurs when in_valid && in_ready. The result is computed combinationally from the current mode and operands, then written into the FIFO tail at that clock edge together with its popcount.
- Latency: a result is visible at the head with out_valid=1 in the cycle after acceptance, provided the FIFO was empty. Otherwise it follows FIFO order.
- Pop: an output transfer occurs when out_valid && out_ready. The head advances at the clock edge.
- in_ready = (fifo_level != FIFO_DEPTH). It is combinational from the registered level only, with no out_ready dependency. When the FIFO is full, a same-cycle pop does NOT permit a push; in_ready stays 0 for that cycle.
- Simultaneous push and pop when not full and not empty: level is unchanged and both pointers advance.
- Pop when empty is impossible (out_valid=0). Push when full is impossible (in_ready=0).
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally from FIFO_DEPTH-1 to 0.
- out_q and out_ones are driven from registered FIFO storage at the read pointer; no combinational path from port_* to out_q.
- match_cnt: increments by 1 on each accepted transfer whose result != 0. It saturates at 2^CNT_W-1.
- cnt_clr=1 sets match_cnt to 0 at the next edge. Clear has priority over a coincident increment.
- Holding rules:
  - in_valid without in_ready: the producer holds its data; the block takes no action.
  - out_valid with out_ready=0: out_q and out_ones hold stable.
- Reset mid-operation: all FIFO contents are discarded immediately. out_valid drops asynchronously.
- Operands are not registered before use: mode and port_* need only be stable in the accepting cycle.

Test Plan:
1. Reset and basic function: reset, then push A=8'hF0, B=8'hCC, C=8'h0F, mode=00 with out_ready=1. Required: next cycle out_valid=1, out_q=8'hCC, out_ones=4, match_cnt=1.
2. All modes: push the same A=8'hF0, B=8'hCC, C=8'h0F with modes 01/10/11. Required: out_q = 8'hC0, 8'hFF and 8'h33 in order, with out_ones = 2, 8 and 4.
3. Fill, backpressure and wrap: hold out_ready=0 and push 5 sets with in_valid=1. Required:
   - 4 are accepted; fifo_level=4 and in_ready=0.
   - In the cycle with out_ready=1 and in_valid=1, there is a pop but no push.
   - Then push and pop continuously for 10 items; results return in order across the pointer wrap.
4. Zero result and counter: push A=0, B=8'hFF, C=0, mode=00. Required: out_q=0, out_ones=0, match_cnt unchanged.
5. Counter saturation and clear (CNT_W=2): accept 5 non-zero results. Required: match_cnt=3.
   - Assert cnt_clr in the same cycle as a non-zero accept. Required: match_cnt=0.
6. Reset mid-stream: assert rst_n=0 between clock edges while 3 entries are queued. Required: out_valid=0 and fifo_level=0 immediately. After release, in_ready=1 and match_cnt=0.
